// File: rtl/rsa_core_arbiter.sv
// rsa_core_arbiter: round-robin sharing of one RSA modexp core among NUM_REQ requesters.
// Flow per job: accept one request, pulse core start, wait for finish, then hold the
// tagged response until it is consumed.
// Optional build macro RSA_ARB_TIMEOUT_EN adds a WAIT watchdog that resets the core and
// returns an error response.
module rsa_core_arbiter #(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned W           = 256,
    parameter int unsigned ID_W        = 1
`ifdef RSA_ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 600000
`endif
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NUM_REQ-1:0]     i_req_valid,
    output logic [NUM_REQ-1:0]     o_req_ready,
    input  logic [NUM_REQ*W-1:0]   i_req_a,
    input  logic [NUM_REQ*W-1:0]   i_req_d,
    input  logic [NUM_REQ*W-1:0]   i_req_n,
    output logic                   o_core_start,
    output logic [W-1:0]           o_core_a,
    output logic [W-1:0]           o_core_d,
    output logic [W-1:0]           o_core_n,
    input  logic [W-1:0]           i_core_result,
    input  logic                   i_core_finished,
    output logic                   o_core_rst,
    output logic                   o_rsp_valid,
    input  logic                   i_rsp_ready,
    output logic [W-1:0]           o_rsp_data,
    output logic [ID_W-1:0]        o_rsp_id,
    output logic                   o_rsp_err,
    output logic                   o_busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e          state_q;
    logic [ID_W-1:0] ptr_q;
    logic            grant_any;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] cand;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_d;
    logic [W-1:0]    sel_n;

`ifdef RSA_ARB_TIMEOUT_EN
    logic [31:0]     wait_cnt_q;
`else
    assign o_core_rst = 1'b0;
    assign o_rsp_err  = 1'b0;
`endif

    // Round-robin search: first valid requester after the last grant, wrapping.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = ID_W'((32'(ptr_q) + i) % NUM_REQ);
            if (!grant_any && i_req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Operand mux for the requester being granted this cycle.
    always_comb begin
        sel_a = '0;
        sel_d = '0;
        sel_n = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (grant_idx == ID_W'(k)) begin
                sel_a = i_req_a[k*W +: W];
                sel_d = i_req_d[k*W +: W];
                sel_n = i_req_n[k*W +: W];
            end
        end
    end

    // Accept strobe: only in IDLE, one-hot on the granted requester.
    always_comb begin
        o_req_ready = '0;
        if (state_q == StIdle && grant_any) begin
            o_req_ready[grant_idx] = 1'b1;
        end
    end

    // Job FSM with registered core and response outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= StIdle;
            ptr_q        <= ID_W'(NUM_REQ - 1);
            o_core_start <= 1'b0;
            o_core_a     <= '0;
            o_core_d     <= '0;
            o_core_n     <= '0;
            o_rsp_valid  <= 1'b0;
            o_rsp_data   <= '0;
            o_rsp_id     <= '0;
            o_busy       <= 1'b0;
`ifdef RSA_ARB_TIMEOUT_EN
            o_core_rst   <= 1'b0;
            o_rsp_err    <= 1'b0;
            wait_cnt_q   <= '0;
`endif
        end else begin
            o_core_start <= 1'b0;
`ifdef RSA_ARB_TIMEOUT_EN
            o_core_rst   <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (grant_any) begin
                        o_core_a     <= sel_a;
                        o_core_d     <= sel_d;
                        o_core_n     <= sel_n;
                        o_rsp_id     <= grant_idx;
                        ptr_q        <= grant_idx;
                        o_core_start <= 1'b1;
                        o_busy       <= 1'b1;
                        state_q      <= StIssue;
                    end
                end
                StIssue: begin
`ifdef RSA_ARB_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                    state_q <= StWait;
                end
                StWait: begin
                    // A finish in the same cycle as the timeout takes priority.
                    if (i_core_finished) begin
                        o_rsp_data  <= i_core_result;
                        o_rsp_valid <= 1'b1;
`ifdef RSA_ARB_TIMEOUT_EN
                        o_rsp_err   <= 1'b0;
`endif
                        state_q     <= StResp;
                    end
`ifdef RSA_ARB_TIMEOUT_EN
                    else if (wait_cnt_q == 32'(TIMEOUT_CYC - 1)) begin
                        o_core_rst  <= 1'b1;
                        o_rsp_data  <= '0;
                        o_rsp_err   <= 1'b1;
                        o_rsp_valid <= 1'b1;
                        state_q     <= StResp;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 32'd1;
                    end
`endif
                end
                StResp: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        o_busy      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
